mul_booth_iter: RTL

Iterative radix-4 Booth multiplier for the EX stage, the multiply counterpart of the team's iterative divider. It executes mul.w / mulh.w / mulh.wu over 18 EX cycles: one setup cycle, then 17 Booth steps. It stalls the pipeline through its own `stall_mul`. The 64-bit product appears in the MEM stage, and the divider's stall/flush handshake is reused unchanged.

---
 rtl/mul_booth_iter.sv | 117 +++++++++++
 1 files changed

// File: rtl/mul_booth_iter.sv
// ============================================================================
// Module   : mul_booth_iter
// Brief    : Iterative radix-4 Booth multiplier, 32x32 -> 64, 18 EX cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_booth_iter (
    input  logic        clk_mul,
    input  logic        rst,
    input  logic        WB_flush_csr,
    input  logic        mul_en,
    input  logic [31:0] mul_x,
    input  logic [31:0] mul_y,
    input  logic        mul_signed,
    output logic        stall_mul,
    output logic [31:0] MEM_mul_lo,
    output logic [31:0] MEM_mul_hi
);

    // Operands are loaded on the edge that leaves DONE, so EX cycle 0 is the
    // DONE&mul_en cycle and Booth steps 0..16 run in CALC during cycles 1..17.
    typedef enum logic [1:0] {
        DONE = 2'd0,
        CALC = 2'd1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  step_q,  step_d;
    logic [67:0] m_q,     m_d;
    logic [34:0] b_q,     b_d;
    logic [67:0] acc_q,   acc_d;
    logic [63:0] prod_q,  prod_d;

    logic [33:0] w_ext_x;
    logic [33:0] w_ext_y;
    logic [67:0] w_term;
    logic [67:0] w_acc_sum;

    assign w_ext_x = {{2{mul_signed & mul_x[31]}}, mul_x};
    assign w_ext_y = {{2{mul_signed & mul_y[31]}}, mul_y};

    // m_q holds A << 2k and b_q[2:0] holds the current triplet B[2k+1:2k-1].
    always_comb begin
        w_term = '0;
        case (b_q[2:0])
            3'b001, 3'b010: w_term = m_q;
            3'b011:         w_term = m_q << 1;
            3'b100:         w_term = -(m_q << 1);
            3'b101, 3'b110: w_term = -m_q;
            default:        w_term = '0;
        endcase
    end

    assign w_acc_sum = acc_q + w_term;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        m_d     = m_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        unique case (state_q)
            DONE: begin
                if (mul_en) begin
                    m_d     = {{34{w_ext_x[33]}}, w_ext_x};
                    b_d     = {w_ext_y, 1'b0};
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = w_acc_sum;
                m_d    = m_q << 2;
                b_d    = {2'b00, b_q[34:2]};
                step_d = step_q + 5'd1;
                if (step_q == 5'd16) begin
                    state_d = DONE;
                    prod_d  = w_acc_sum[63:0];
                end
            end
            default: state_d = DONE;
        endcase
        if (WB_flush_csr) begin
            state_d = DONE;
            prod_d  = '0;
        end
    end

    always_ff @(posedge clk_mul or posedge rst) begin
        if (rst) begin
            state_q <= DONE;
            step_q  <= '0;
            m_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            m_q     <= m_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    // Released in the last step so the instruction reaches MEM with the result.
    assign stall_mul  = mul_en & ~rst & ~((state_q == CALC) && (step_q == 5'd16));
    assign MEM_mul_lo = prod_q[31:0];
    assign MEM_mul_hi = prod_q[63:32];

endmodule

`default_nettype wire
